prost_sbox_share_io: RTL and testbench

Sequencing front/back end for the two-share, first-order masked PROST S-box core. It accepts an unmasked nibble over a valid/ready handshake and splits it into two Boolean shares using fresh randomness. It drives the shares and the 8-bit gadget randomness into the core, waits out the core's register stage, then recombines the two output shares into an unmasked nibble and presents it over a second valid/ready handshake. The block is the driver (transmitter) and collector for the masked core in S-box-level test harnesses and in the round datapath wrapper.

---
 rtl/prost_sbox_share_io_if.sv | 34 +++
 rtl/prost_sbox_share_io.sv | 96 +++++++++
 tb/tb_prost_sbox_share_io.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/prost_sbox_share_io_if.sv
// prost_sbox_share_io_if: handshake and share bus between the masked S-box front/back end and its harness.
//   in_data/in_valid/in_ready  unmasked nibble input handshake
//   rnd                        fresh randomness (mask in [3:0], core randomness in [11:4])
//   sh0/sh1/ran                shares and gadget randomness toward the masked core
//   res0/res1                  output shares returned by the masked core
//   out_data/out_valid/out_ready  recombined nibble output handshake
//   err                        golden-model mismatch, only when PROST_IO_CHECK_EN is defined
// master: harness / core side.  slave: the prost_sbox_share_io block.
interface prost_sbox_share_io_if;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] rnd;
    logic [3:0]  sh0;
    logic [3:0]  sh1;
    logic [7:0]  ran;
    logic [3:0]  res0;
    logic [3:0]  res1;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef PROST_IO_CHECK_EN
    logic        err;
    modport master (output in_data, in_valid, rnd, res0, res1, out_ready,
                    input in_ready, sh0, sh1, ran, out_data, out_valid, err);
    modport slave (input in_data, in_valid, rnd, res0, res1, out_ready,
                   output in_ready, sh0, sh1, ran, out_data, out_valid, err);
`else
    modport master (output in_data, in_valid, rnd, res0, res1, out_ready,
                    input in_ready, sh0, sh1, ran, out_data, out_valid);
    modport slave (input in_data, in_valid, rnd, res0, res1, out_ready,
                   output in_ready, sh0, sh1, ran, out_data, out_valid);
`endif
endinterface

// File: rtl/prost_sbox_share_io.sv
// prost_sbox_share_io: splits a nibble into two Boolean shares for the masked PROST S-box core and recombines its result.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    prost_sbox_share_io_if.slave (input handshake, shares/randomness to core, core results, output handshake)
// Optional PROST_IO_CHECK_EN: latches the plaintext and flags err when the recombined result differs
// from the reference S-box. Verification builds only, since it keeps the unmasked input in a register.
module prost_sbox_share_io (
    input logic                   clk,
    input logic                   rst_n,
    prost_sbox_share_io_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CAPT, OUT} state_t;

    state_t     state_q, state_d;
    logic [3:0] sh0_q, sh0_d, sh1_q, sh1_d, out_q, out_d;
    logic [7:0] ran_q, ran_d;
    logic       acc, done;

    assign acc  = bus.in_valid && state_q == IDLE;
    assign done = bus.out_ready && state_q == OUT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = acc               ? LOAD :
                  state_q == LOAD   ? CAPT :
                  state_q == CAPT   ? OUT  :
                  done              ? IDLE : state_q;
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == OUT;
    end

    // Shares live only during LOAD; every other cycle they load zero, which scrubs them after E1.
    always_comb begin
        sh0_d = acc ? bus.in_data ^ bus.rnd[3:0] : 4'h0;
        sh1_d = acc ? bus.rnd[3:0] : 4'h0;
        ran_d = acc ? bus.rnd[11:4] : 8'h0;
        out_d = state_q == CAPT ? bus.res0 ^ bus.res1 : done ? 4'h0 : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0_q <= '0;
            sh1_q <= '0;
            ran_q <= '0;
            out_q <= '0;
        end else begin
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            ran_q <= ran_d;
            out_q <= out_d;
        end
    end

    assign bus.sh0      = sh0_q;
    assign bus.sh1      = sh1_q;
    assign bus.ran      = ran_q;
    assign bus.out_data = out_q;

`ifdef PROST_IO_CHECK_EN
    logic [3:0] pt_q, pt_d;
    logic       err_q, err_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h0;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'h8;  4'h3: sbox = 4'hF;
            4'h4: sbox = 4'h1;  4'h5: sbox = 4'h5;  4'h6: sbox = 4'hE;  4'h7: sbox = 4'h9;
            4'h8: sbox = 4'h2;  4'h9: sbox = 4'h7;  4'hA: sbox = 4'hA;  4'hB: sbox = 4'hC;
            4'hC: sbox = 4'hB;  4'hD: sbox = 4'hD;  4'hE: sbox = 4'h6;  default: sbox = 4'h3;
        endcase
    endfunction

    always_comb begin
        pt_d  = acc ? bus.in_data : pt_q;
        err_d = state_q == CAPT ? (bus.res0 ^ bus.res1) != sbox(pt_q) : done ? 1'b0 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pt_q  <= pt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_prost_sbox_share_io.sv
// tb_prost_sbox_share_io: directed bench for the masked PROST S-box share front/back end.
module tb_prost_sbox_share_io;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flip = 1'b0;
    logic [3:0] core_v = 4'h0;
    logic [3:0] core_m = 4'h0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] tp_in [8] = '{4'h1, 4'hA, 4'h6, 4'hF, 4'h0, 4'h8, 4'hD, 4'h4};
    int         acc_cyc [8];
    int         n_acc = 0;
    int         n_res = 0;

    prost_sbox_share_io_if bus();

    prost_sbox_share_io dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h0;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'h8;  4'h3: sbox = 4'hF;
            4'h4: sbox = 4'h1;  4'h5: sbox = 4'h5;  4'h6: sbox = 4'hE;  4'h7: sbox = 4'h9;
            4'h8: sbox = 4'h2;  4'h9: sbox = 4'h7;  4'hA: sbox = 4'hA;  4'hB: sbox = 4'hC;
            4'hC: sbox = 4'hB;  4'hD: sbox = 4'hD;  4'hE: sbox = 4'h6;  default: sbox = 4'h3;
        endcase
    endfunction

    // Stand-in for the masked core: one register stage, output re-shared with a fresh random mask.
    always_ff @(posedge clk) begin
        core_v <= sbox(bus.sh0 ^ bus.sh1);
        core_m <= 4'($urandom);
    end
    assign bus.res0 = core_m ^ {3'b000, flip};
    assign bus.res1 = core_m ^ core_v;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction with out_ready high; inputs driven and outputs sampled on the falling edge.
    task automatic txn(input logic [3:0] d, input logic [11:0] r, input logic f);
        @(negedge clk);
        flip = f;
        bus.in_data = d;
        bus.rnd = r;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        check("in_ready_idle", 16'(bus.in_ready), 16'h1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rnd = 12'($urandom);
        check("sh1_load", 16'(bus.sh1), 16'(r[3:0]));
        check("sh0_load", 16'(bus.sh0), 16'(d ^ r[3:0]));
        check("ran_load", 16'(bus.ran), 16'(r[11:4]));
        check("in_ready_busy", 16'(bus.in_ready), 16'h0);
        @(negedge clk);
        check("scrub_capt", {bus.sh0, bus.sh1, bus.ran}, 16'h0);
        check("valid_early", 16'(bus.out_valid), 16'h0);
        @(negedge clk);
        check("valid_lat2", 16'(bus.out_valid), 16'h1);
        check("out_data", 16'(bus.out_data), 16'(sbox(d) ^ {3'b000, f}));
`ifdef PROST_IO_CHECK_EN
        check("err", 16'(bus.err), 16'(f));
`endif
        @(negedge clk);
        flip = 1'b0;
        check("out_clear", {11'h0, bus.out_valid, bus.out_data}, 16'h0);
    endtask

    initial begin
        bus.in_data = 4'h0;
        bus.in_valid = 1'b0;
        bus.rnd = 12'h0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 16'(bus.in_ready), 16'h1);
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_out_data", 16'(bus.out_data), 16'h0);
        check("rst_shares", {bus.sh0, bus.sh1, bus.ran}, 16'h0);
`ifdef PROST_IO_CHECK_EN
        check("rst_err", 16'(bus.err), 16'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) txn(4'(i), 12'($urandom), 1'b0);

        txn(4'h7, 12'h000, 1'b0);
        txn(4'h7, 12'hFFF, 1'b0);
        txn(4'h7, 12'hA5C, 1'b0);

        // Backpressure with a competing input held valid.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_data = 4'h3;
        bus.rnd = 12'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_data = 4'h5;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", 16'(bus.out_valid), 16'h1);
            check("bp_data", 16'(bus.out_data), 16'hF);
            check("bp_in_ready", 16'(bus.in_ready), 16'h0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 16'(bus.in_ready), 16'h1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_shares", 16'(bus.sh0 ^ bus.sh1), 16'h5);
        @(negedge clk);
        @(negedge clk);
        check("bp_second_valid", 16'(bus.out_valid), 16'h1);
        check("bp_second_data", 16'(bus.out_data), 16'(sbox(4'h5)));
        @(negedge clk);

        // Reset while in LOAD.
        bus.in_data = 4'h9;
        bus.rnd = 12'h5A3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("load_sh1_before_rst", 16'(bus.sh1), 16'h3);
        rst_n = 1'b0;
        #1;
        check("rst_load_shares", {bus.sh0, bus.sh1, bus.ran}, 16'h0);
        check("rst_load_in_ready", 16'(bus.in_ready), 16'h1);
        check("rst_load_valid", 16'(bus.out_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_load_no_valid", 16'(bus.out_valid), 16'h0);
        end

        // Reset while in OUT.
        bus.out_ready = 1'b0;
        bus.in_data = 4'h9;
        bus.rnd = 12'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("out_before_rst", {11'h0, bus.out_valid, bus.out_data}, {11'h0, 1'b1, sbox(4'h9)});
        rst_n = 1'b0;
        #1;
        check("rst_out_valid_mid", 16'(bus.out_valid), 16'h0);
        check("rst_out_data_mid", 16'(bus.out_data), 16'h0);
        check("rst_out_in_ready", 16'(bus.in_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_out_no_valid", 16'(bus.out_valid), 16'h0);
        end
        txn(4'hC, 12'($urandom), 1'b0);

        // Back-to-back throughput with both handshakes held high.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && n_res < 8) begin
                check("tp_out", 16'(bus.out_data), 16'(sbox(tp_in[n_res])));
                n_res++;
            end
            if (bus.in_ready) begin
                if (n_acc < 8) begin
                    bus.in_data = tp_in[n_acc];
                    bus.rnd = 12'($urandom);
                    acc_cyc[n_acc] = c;
                    n_acc++;
                end else bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("tp_accepts", 16'(n_acc), 16'd8);
        check("tp_results", 16'(n_res), 16'd8);
        for (int i = 1; i < 8; i++) check("tp_interval", 16'(acc_cyc[i] - acc_cyc[i-1]), 16'd4);

`ifdef PROST_IO_CHECK_EN
        txn(4'h0, 12'($urandom), 1'b1);
        txn(4'h0, 12'($urandom), 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
